lfsr_serial_collector: RTL
==========================

// Module: lfsr_serial_collector
// PURPOSE
//  Downstream stage of the 8-bit LFSR generator. Collects the serial OUT stream, LSB first, while the generator
//  shifts (out_enable high) and assembles WIDTH-bit words. Completed words go through a small FIFO and leave on a
//  valid/ready parallel port, so a slow consumer never stalls the generator.
// PARAMETERS
//  WIDTH       8   bits per assembled word (also bits shifted out per generator unload)
//  FIFO_DEPTH  2   completed-word buffer entries (power of 2, >=2)
// PORTS
//  clk          in   1          rising-edge clock, shared with the LFSR generator
//  reset        in   1          asynchronous, active-low reset
//  shift_en     in   1          copy of generator out_enable; serial_in is meaningful the cycle after it is high
//  serial_in    in   1          generator OUT bit
//  serial_vld   in   1          generator valid (sticky-high after its first unload)
//  clear        in   1          sync flush: drop partial word and FIFO contents, clear overflow
//  par_data     out  WIDTH      head-of-FIFO word, bit0 = first bit received
//  par_valid    out  1          par_data holds a word
//  par_ready    in   1          consumer accepts the word; transfer = par_valid & par_ready
//  overflow     out  1          sticky: a word completed while the FIFO was full
//  word_cnt     out  8          completed words pushed since reset/clear, wraps 255->0
// BEHAVIOUR
//  - Reset (async, active-low): shift_d=0, bit_cnt=0, shreg=0, FIFO empty, par_valid=0, par_data=0,
//    overflow=0, word_cnt=0, state=IDLE. Assert or deassert at any point, mid-word included: the partial word is lost.
//  - Sample strobe: shift_d <= shift_en. A bit is taken in cycle t when shift_d & serial_vld at the edge ending t.
//  - Assembly: shreg <= {serial_in, shreg[WIDTH-1:1]}, so the first bit lands in bit0 after WIDTH samples.
//    bit_cnt counts 0..WIDTH-1.
//  - FSM states IDLE, COLLECT:
//      IDLE    -> COLLECT on the first sample. That bit is stored and bit_cnt becomes 1.
//      COLLECT -> stays while samples arrive. Gaps (no sample) are allowed and hold state.
//              -> on the WIDTH-th sample: push {serial_in, shreg[WIDTH-1:1]} into the FIFO, bit_cnt=0, go to IDLE.
//  - Push latency: par_valid rises the cycle after the WIDTH-th sample when the FIFO was empty (fall-through head register).
//  - FIFO full when the word completes: the word is dropped, overflow <= 1, word_cnt unchanged. Full is evaluated
//    after the same-cycle pop, so push and pop in the same cycle on a full FIFO succeeds.
//  - Pop on par_valid & par_ready. par_data is stable while par_valid & ~par_ready.
//  - word_cnt increments on every successful push only. Wraps modulo 256.
//  - clear has priority over sample, push and pop in its cycle. Next cycle: state=IDLE, bit_cnt=0, FIFO empty,
//    par_valid=0, overflow=0, word_cnt=0.
//  - serial_vld low: samples are ignored even with shift_d high, which covers pre-first-unload garbage.
// STRUCTURE
//  - Shared package lfsr_pkg: LFSR_W=8, collector state enum {IDLE, COLLECT}, localparam CNT_W=$clog2(WIDTH).
//  - One sub-module: sync_fifo (WIDTH x FIFO_DEPTH, push/pop/full/empty, fall-through head). The top level holds the
//    strobe register, shift register, FSM, counters and overflow logic.
// TESTING
//  - Drive the generator with seed 8'hA5 and 8 shift_en cycles, par_ready=1 -> one word 8'hA5 on par_valid,
//    word_cnt=1, overflow=0.
//  - Repeat with 3 shift_en, 4 idle cycles, 5 shift_en, seed 8'h3C -> gap tolerated, word 8'h3C.
//  - par_ready=0 for 3 words, FIFO_DEPTH=2 -> first two words held in order, overflow=1 after the third,
//    word_cnt=2. Raise par_ready -> exactly the two buffered words drain.
//  - FIFO full, and the 8th sample arrives in the same cycle as a pop -> push accepted, overflow stays 0.
//  - reset pulsed low after 4 of 8 bits -> all outputs 0 immediately. The next 8 samples from seed 8'h81
//    give word 8'h81.
//  - clear in the same cycle as the 8th sample with one word queued -> no word emitted, par_valid=0,
//    word_cnt=0, overflow=0 next cycle.

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR generator and its serial collector.
package lfsr_pkg;

    localparam int unsigned LFSR_W = 8;
    localparam int unsigned CNT_W  = $clog2(LFSR_W);

    typedef enum logic {
        IDLE,
        COLLECT
    } coll_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with a fall-through head: entry 0 is the registered head word.
module sync_fifo #(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         valid,
    output logic         full_c
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem   [DEPTH];
    logic [W-1:0]  mem_n [DEPTH];
    logic [CW-1:0] count;
    logic [CW-1:0] count_n;
    logic [CW-1:0] wr_idx;

    assign full_c = (count == CW'(DEPTH));
    assign dout   = mem[0];

    // Pop shifts entries toward the head; push lands just past the post-pop tail.
    always_comb begin
        mem_n   = mem;
        count_n = count;
        wr_idx  = count - CW'(pop);
        if (pop) begin
            for (int i = 0; i < int'(DEPTH) - 1; i++) begin
                mem_n[i] = mem[i+1];
            end
        end
        if (push) begin
            mem_n[AW'(wr_idx)] = din;
        end
        count_n = count + CW'(push) - CW'(pop);
        if (clear) begin
            count_n = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
            count <= '0;
            valid <= 1'b0;
        end else begin
            mem   <= mem_n;
            count <= count_n;
            valid <= (count_n != '0);
        end
    end

endmodule

// File: rtl/lfsr_serial_collector.sv
// Collects the LFSR serial stream LSB first into words and buffers them for a valid/ready consumer.
module lfsr_serial_collector
    import lfsr_pkg::*;
#(
    parameter int unsigned WIDTH      = LFSR_W,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             shift_en,
    input  logic             serial_in,
    input  logic             serial_vld,
    input  logic             clear,
    output logic [WIDTH-1:0] par_data,
    output logic             par_valid,
    input  logic             par_ready,
    output logic             overflow,
    output logic [7:0]       word_cnt
);

    localparam int unsigned BIT_W = $clog2(WIDTH);

    coll_state_t      state;
    coll_state_t      state_n;
    logic [BIT_W-1:0] bit_cnt;
    logic [BIT_W-1:0] bit_cnt_n;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_n;
    logic [WIDTH-1:0] word_c;
    logic             shift_d;
    logic             sample_c;
    logic             push_req_c;
    logic             push_c;
    logic             pop_c;
    logic             full_c;
    logic             ovf_set_c;

    // Next-state, assembly and FIFO handshake; clear overrides everything in its cycle.
    always_comb begin
        state_n    = state;
        bit_cnt_n  = bit_cnt;
        shreg_n    = shreg;
        push_req_c = 1'b0;
        sample_c   = shift_d & serial_vld;
        word_c     = {serial_in, shreg[WIDTH-1:1]};
        pop_c      = par_valid & par_ready & ~clear;

        if (clear) begin
            state_n   = IDLE;
            bit_cnt_n = '0;
        end else if (sample_c) begin
            shreg_n = word_c;
            case (state)
                IDLE: begin
                    state_n   = COLLECT;
                    bit_cnt_n = BIT_W'(1);
                end
                COLLECT: begin
                    if (bit_cnt == BIT_W'(WIDTH - 1)) begin
                        push_req_c = 1'b1;
                        bit_cnt_n  = '0;
                        state_n    = IDLE;
                    end else begin
                        bit_cnt_n = bit_cnt + BIT_W'(1);
                    end
                end
                default: begin
                    state_n   = IDLE;
                    bit_cnt_n = '0;
                end
            endcase
        end

        // Fullness is judged after the same-cycle pop.
        push_c    = push_req_c & (~full_c | pop_c);
        ovf_set_c = push_req_c & ~push_c;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            shreg    <= '0;
            shift_d  <= 1'b0;
            overflow <= 1'b0;
            word_cnt <= '0;
        end else begin
            state   <= state_n;
            bit_cnt <= bit_cnt_n;
            shreg   <= shreg_n;
            shift_d <= shift_en;
            if (clear) begin
                overflow <= 1'b0;
                word_cnt <= '0;
            end else begin
                if (ovf_set_c) begin
                    overflow <= 1'b1;
                end
                if (push_c) begin
                    word_cnt <= word_cnt + 8'd1;
                end
            end
        end
    end

    sync_fifo #(
        .W     (WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .clear  (clear),
        .push   (push_c),
        .pop    (pop_c),
        .din    (word_c),
        .dout   (par_data),
        .valid  (par_valid),
        .full_c (full_c)
    );

endmodule
